pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/pll_lock_sequencer.sv | 154 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer.
//   state_t   - sequencer FSM states
//   LOSS_W    - width of the lock-loss counter output
//   cnt_width - width for a counter that must reach the largest of three limits
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam int unsigned LOSS_W = 8;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return 32'($unsigned($clog2(m))) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser, both flops cleared by synchronous reset.
//   i_clk  - destination clock
//   i_rst  - synchronous active-high reset
//   i_d    - asynchronous input
//   o_q    - synchronised output (2-cycle latency)
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings a PLL out of reset, waits for a stable lock, then
// releases the downstream core reset. Retries on lock timeout and enters FAULT
// after RETRY_LIMIT consecutive failures.
//   clock      - reference clock, all logic on rising edge
//   reset      - synchronous active-high reset
//   locked     - PLL LOCK (asynchronous, synchronised internally)
//   restart    - single-cycle pulse forcing a new start sequence
//   pll_resetb - PLL RESETB, 0 holds the PLL in reset
//   core_reset - active-high reset for logic on the PLL output clock
//   ready      - high only in RUN
//   fault      - high only in FAULT
//   loss_count - saturating count of lock losses in RUN
// Build option: define PLL_LOSS_COUNTER_EN to build the loss counter;
// otherwise loss_count is tied to zero.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RESET_CYCLES    = 48,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 48000,
  parameter int unsigned LOCK_STABLE_CYCLES  = 4800,
  parameter int unsigned RETRY_LIMIT         = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              locked,
  input  logic              restart,
  output logic              pll_resetb,
  output logic              core_reset,
  output logic              ready,
  output logic              fault,
  output logic [LOSS_W-1:0] loss_count
);

  localparam int unsigned CW = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                         LOCK_STABLE_CYCLES);
  localparam int unsigned RW = cnt_width(RETRY_LIMIT, 1, 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_next_cnt;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_next_retry;
  logic          w_locked_s;
  logic          r_pll_resetb;
  logic          r_core_reset;
  logic          r_ready;
  logic          r_fault;

  sync_2ff u_sync_locked (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (locked),
    .o_q   (w_locked_s)
  );

  // Lock-drop checks come before terminal-count checks so a drop always wins.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt + 1'b1;
    w_next_retry = r_retry;
    if (restart) begin
      w_next_state = S_PLL_RST;
      w_next_cnt   = '0;
      w_next_retry = '0;
    end else begin
      case (r_state)
        S_PLL_RST: begin
          if (r_cnt == CW'(PLL_RESET_CYCLES - 1)) begin
            w_next_state = S_WAIT_LOCK;
            w_next_cnt   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (w_locked_s) begin
            w_next_state = S_STABLE;
            w_next_cnt   = '0;
          end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            w_next_cnt   = '0;
            w_next_retry = r_retry + 1'b1;
            w_next_state = (w_next_retry == RW'(RETRY_LIMIT)) ? S_FAULT : S_PLL_RST;
          end
        end
        S_STABLE: begin
          if (!w_locked_s) begin
            w_next_state = S_WAIT_LOCK;
            w_next_cnt   = '0;
          end else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            w_next_state = S_RUN;
            w_next_cnt   = '0;
            w_next_retry = '0;
          end
        end
        S_RUN: begin
          w_next_cnt = '0;
          if (!w_locked_s) w_next_state = S_PLL_RST;
        end
        S_FAULT: w_next_cnt = '0;
        default: begin
          w_next_state = S_PLL_RST;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register while still coming straight from flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_pll_resetb <= 1'b0;
      r_core_reset <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_retry      <= w_next_retry;
      r_pll_resetb <= (w_next_state != S_PLL_RST) && (w_next_state != S_FAULT);
      r_core_reset <= (w_next_state != S_RUN);
      r_ready      <= (w_next_state == S_RUN);
      r_fault      <= (w_next_state == S_FAULT);
    end
  end

  assign pll_resetb = r_pll_resetb;
  assign core_reset = r_core_reset;
  assign ready      = r_ready;
  assign fault      = r_fault;

`ifdef PLL_LOSS_COUNTER_EN
  logic [LOSS_W-1:0] r_loss_count;
  logic              w_loss;

  // A restart in the same cycle pre-empts the loss transition, so it is not counted.
  assign w_loss = (r_state == S_RUN) && !w_locked_s && !restart;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_loss_count <= '0;
    end else if (w_loss && (r_loss_count != '1)) begin
      r_loss_count <= r_loss_count + 1'b1;
    end
  end

  assign loss_count = r_loss_count;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer (PLL_RESET_CYCLES=4,
// LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, RETRY_LIMIT=3).
// Cycle n means "just after the n-th rising edge following reset release";
// an input changed after edge n is first sampled at edge n+1. locked sampled
// at edge n reaches the FSM at edge n+2.
module tb_pll_lock_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       locked;
  logic       restart;
  logic       pll_resetb;
  logic       core_reset;
  logic       ready;
  logic       fault;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

`ifdef PLL_LOSS_COUNTER_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  always #5 clock = ~clock;

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (20),
    .LOCK_STABLE_CYCLES  (8),
    .RETRY_LIMIT         (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .locked     (locked),
    .restart    (restart),
    .pll_resetb (pll_resetb),
    .core_reset (core_reset),
    .ready      (ready),
    .fault      (fault),
    .loss_count (loss_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    restart = 1'b0;
    locked  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL reset_pll_resetb: got %b expected 0", pll_resetb); end
    checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL reset_loss_count: got %0d expected 0", loss_count); end
  endtask

  // locked high from edge 10: STABLE at 12, RUN at 20.
  task automatic test_clean_start();
    do_reset();
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 3) begin
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL clean_resetb_c3: got %b expected 0", pll_resetb); end
      end
      if (n == 4) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL clean_resetb_c4: got %b expected 1", pll_resetb); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL clean_core_reset_c4: got %b expected 1", core_reset); end
      end
      if (n == 19) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL clean_ready_c19: got %b expected 0", ready); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL clean_core_reset_c19: got %b expected 1", core_reset); end
      end
      if (n == 20) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clean_ready_c20: got %b expected 1", ready); end
        checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL clean_core_reset_c20: got %b expected 0", core_reset); end
      end
      if (n == 30) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL clean_ready_held: got %b expected 1", ready); end
      end
      if (n == 9) locked = 1'b1;
    end
  endtask

  // From RUN: locked low at edge 1 only -> PLL_RST at 3, WAIT at 7, RUN at 16.
  task automatic test_loss_in_run();
    logic [7:0] exp_lc;
    exp_lc = LC_EN ? 8'd1 : 8'd0;
    locked = 1'b0;
    for (int m = 1; m <= 20; m++) begin
      tick();
      if (m == 1) locked = 1'b1;
      if (m == 2) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_m2: got %b expected 1", ready); end
      end
      if (m == 3) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready_m3: got %b expected 0", ready); end
        checks++; if (core_reset !== 1'b1) begin errors++; $display("FAIL loss_core_reset_m3: got %b expected 1", core_reset); end
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_resetb_m3: got %b expected 0", pll_resetb); end
        checks++; if (loss_count !== exp_lc) begin errors++; $display("FAIL loss_count_1: got %0d expected %0d", loss_count, exp_lc); end
      end
      if (m == 6) begin
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_resetb_m6: got %b expected 0", pll_resetb); end
      end
      if (m == 7) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL loss_resetb_m7: got %b expected 1", pll_resetb); end
      end
      if (m == 15) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready_m15: got %b expected 0", ready); end
      end
      if (m == 16) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL loss_ready_m16: got %b expected 1", ready); end
        checks++; if (core_reset !== 1'b0) begin errors++; $display("FAIL loss_core_reset_m16: got %b expected 0", core_reset); end
      end
    end
  endtask

  // Losses 2..256, each followed by a full resequence back into RUN.
  task automatic test_loss_saturation();
    logic [7:0] exp_lc;
    for (int i = 2; i <= 256; i++) begin
      locked = 1'b0;
      tick();
      locked = 1'b1;
      repeat (19) tick();
      if (i == 100 || i == 255 || i == 256) begin
        exp_lc = LC_EN ? ((i > 255) ? 8'd255 : 8'(i)) : 8'd0;
        checks++; if (loss_count !== exp_lc) begin errors++; $display("FAIL loss_count_%0d: got %0d expected %0d", i, loss_count, exp_lc); end
      end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sat_ready_end: got %b expected 1", ready); end
  endtask

  // Drop sampled at edge 15 -> WAIT at 17, STABLE at 18, RUN at 26.
  task automatic test_stable_glitch();
    do_reset();
    checks++; if (loss_count !== 8'd0) begin errors++; $display("FAIL glitch_loss_cleared: got %0d expected 0", loss_count); end
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (n == 9)  locked = 1'b1;
      if (n == 14) locked = 1'b0;
      if (n == 15) locked = 1'b1;
      if (n == 20) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_c20: got %b expected 0", ready); end
      end
      if (n == 25) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL glitch_ready_c25: got %b expected 0", ready); end
      end
      if (n == 26) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready_c26: got %b expected 1", ready); end
      end
    end
  endtask

  // Timeouts at 24, 48, 72 (FAULT); restart at 101; three more timeouts -> FAULT at 173.
  task automatic test_never_lock();
    int low_cycles;
    low_cycles = 0;
    do_reset();
    for (int n = 1; n <= 173; n++) begin
      tick();
      if (n <= 71 && pll_resetb === 1'b0) low_cycles++;
      if (n == 23) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL nolock_resetb_c23: got %b expected 1", pll_resetb); end
      end
      if (n == 24) begin
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL nolock_resetb_c24: got %b expected 0", pll_resetb); end
      end
      if (n == 28) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL nolock_resetb_c28: got %b expected 1", pll_resetb); end
      end
      if (n == 71) begin
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL nolock_fault_c71: got %b expected 0", fault); end
        checks++; if (low_cycles != 11) begin errors++; $display("FAIL nolock_reset_low_cycles: got %0d expected 11", low_cycles); end
      end
      if (n == 72) begin
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL nolock_fault_c72: got %b expected 1", fault); end
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL nolock_resetb_c72: got %b expected 0", pll_resetb); end
      end
      if (n == 100) begin
        checks++; if (fault !== 1'b1 || pll_resetb !== 1'b0) begin errors++; $display("FAIL nolock_fault_held: got fault=%b resetb=%b expected fault=1 resetb=0", fault, pll_resetb); end
        restart = 1'b1;
      end
      if (n == 101) begin
        restart = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL restart_fault_c101: got %b expected 0", fault); end
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL restart_resetb_c101: got %b expected 0", pll_resetb); end
      end
      if (n == 104) begin
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL restart_resetb_c104: got %b expected 0", pll_resetb); end
      end
      if (n == 105) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL restart_resetb_c105: got %b expected 1", pll_resetb); end
      end
      if (n == 172) begin
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL restart_fault_c172: got %b expected 0", fault); end
      end
      if (n == 173) begin
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL restart_fault_c173: got %b expected 1", fault); end
      end
    end
  endtask

  // RUN at 20; locked_s low and restart both at edge 30 -> PLL_RST at 30, WAIT at 34,
  // locked stays low so FAULT after three timeouts (54, 78, 102).
  task automatic test_simultaneous();
    do_reset();
    for (int n = 1; n <= 102; n++) begin
      tick();
      if (n == 9)  locked = 1'b1;
      if (n == 27) locked = 1'b0;
      if (n == 29) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL simul_ready_c29: got %b expected 1", ready); end
        restart = 1'b1;
      end
      if (n == 30) begin
        restart = 1'b0;
        checks++; if (ready !== 1'b0 || core_reset !== 1'b1 || pll_resetb !== 1'b0) begin
          errors++; $display("FAIL simul_outputs_c30: got ready=%b core_reset=%b resetb=%b expected 0 1 0", ready, core_reset, pll_resetb);
        end
      end
      if (n == 33) begin
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL simul_resetb_c33: got %b expected 0", pll_resetb); end
      end
      if (n == 34) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL simul_resetb_c34: got %b expected 1", pll_resetb); end
      end
      if (n == 101) begin
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL simul_fault_c101: got %b expected 0", fault); end
      end
      if (n == 102) begin
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL simul_fault_c102: got %b expected 1", fault); end
      end
    end
  endtask

  // STABLE from 12; reset sampled at 15; after release locked is already high:
  // WAIT at m=4, STABLE at 5, RUN at 13.
  task automatic test_reset_in_stable();
    do_reset();
    for (int n = 1; n <= 15; n++) begin
      tick();
      if (n == 9) locked = 1'b1;
      if (n == 14) begin
        checks++; if (pll_resetb !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL rst_stable_pre: got resetb=%b ready=%b expected 1 0", pll_resetb, ready); end
        reset = 1'b1;
      end
    end
    checks++; if (pll_resetb !== 1'b0 || core_reset !== 1'b1 || ready !== 1'b0 || fault !== 1'b0 || loss_count !== 8'd0) begin
      errors++; $display("FAIL rst_stable_outputs: got resetb=%b core_reset=%b ready=%b fault=%b loss=%0d expected 0 1 0 0 0",
                         pll_resetb, core_reset, ready, fault, loss_count);
    end
    reset = 1'b0;
    for (int m = 1; m <= 13; m++) begin
      tick();
      if (m == 3) begin
        checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rst_stable_resetb_m3: got %b expected 0", pll_resetb); end
      end
      if (m == 4) begin
        checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL rst_stable_resetb_m4: got %b expected 1", pll_resetb); end
      end
      if (m == 12) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_stable_ready_m12: got %b expected 0", ready); end
      end
      if (m == 13) begin
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_stable_ready_m13: got %b expected 1", ready); end
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    test_reset();
    test_clean_start();
    test_loss_in_run();
    test_loss_saturation();
    test_stable_glitch();
    test_never_lock();
    test_simultaneous();
    test_reset_in_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
